eth_tx_arb: RTL and testbench

//  Round-robin scheduler sharing one RMII eth_tx frame engine and its packet RAM among NUM_REQ requesters.

---
 rtl/eth_tx_arb.sv | 164 ++++++++++++++++
 tb/tb_eth_tx_arb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arb.sv
// Round-robin arbiter sharing one RMII eth_tx engine and its packet RAM pages among NUM_REQ requesters.
// Optional ETH_TX_ARB_STATS_EN adds frame/rejection counters.
module eth_tx_arb #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned PAKET_MAX_SIZE = 1500,
  parameter int unsigned IFG_CLKS       = 48
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ*11-1:0] i_size,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [NUM_REQ-1:0]   o_done,
  output logic [NUM_REQ-1:0]   o_err,
  output logic                 o_tx_en,
  input  logic                 i_tx_ready,
  output logic [10:0]          o_tx_size,
  output logic [1:0]           o_ram_page
`ifdef ETH_TX_ARB_STATS_EN
  ,
  output logic [15:0]          o_frm_cnt,
  output logic [15:0]          o_rej_cnt
`endif
);

  localparam int unsigned SIZE_W = 11;
  localparam int unsigned PAGE_W = 2;
  localparam int unsigned IFG_W  = $clog2(IFG_CLKS + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, IFG} state_t;

  state_t              state, state_d;
  logic [PAGE_W-1:0]   rr_ptr, rr_d;
  logic [IFG_W-1:0]    ifg_cnt, ifg_d;
  logic                seen_ready, seen_d;
  logic                ready_q;
  logic [NUM_REQ-1:0]  grant_d, done_d, err_d;
  logic                tx_en_d;
  logic [SIZE_W-1:0]   size_d;
  logic [PAGE_W-1:0]   page_d;

  logic                hi_ok, lo_ok, pick_valid, size_ok;
  logic [PAGE_W-1:0]   hi_idx, lo_idx, pick_idx;
  logic [SIZE_W-1:0]   pick_size;

  // First requester after rr_ptr: search above the pointer, then wrap to the bottom.
  always_comb begin
    hi_ok  = 1'b0;
    lo_ok  = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (i_req[j] && (j > 32'(rr_ptr)) && !hi_ok) begin
        hi_ok  = 1'b1;
        hi_idx = PAGE_W'(j);
      end
      if (i_req[j] && (j <= 32'(rr_ptr)) && !lo_ok) begin
        lo_ok  = 1'b1;
        lo_idx = PAGE_W'(j);
      end
    end
    pick_valid = hi_ok | lo_ok;
    pick_idx   = hi_ok ? hi_idx : lo_idx;
    pick_size  = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (PAGE_W'(j) == pick_idx) pick_size = i_size[j*SIZE_W +: SIZE_W];
    end
    size_ok = (pick_size != '0) && (pick_size <= SIZE_W'(PAKET_MAX_SIZE));
  end

  always_comb begin
    state_d = state;
    rr_d    = rr_ptr;
    ifg_d   = ifg_cnt;
    seen_d  = seen_ready;
    grant_d = o_grant;
    done_d  = '0;
    err_d   = '0;
    tx_en_d = o_tx_en;
    size_d  = o_tx_size;
    page_d  = o_ram_page;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          page_d = pick_idx;
          size_d = pick_size;
          rr_d   = pick_idx;
          if (size_ok) begin
            grant_d = NUM_REQ'(1) << pick_idx;
            seen_d  = 1'b0;
            state_d = START;
          end else begin
            err_d = NUM_REQ'(1) << pick_idx;
          end
        end
      end
      // Acceptance is a ready low seen only after the engine has shown ready high.
      START: begin
        if (seen_ready && !i_tx_ready) begin
          tx_en_d = 1'b0;
          state_d = WAIT_DONE;
        end else begin
          tx_en_d = 1'b1;
          if (i_tx_ready) seen_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (i_tx_ready && !ready_q) begin
          done_d  = o_grant;
          grant_d = '0;
          ifg_d   = '0;
          state_d = IFG;
        end
      end
      // The done cycle and the IDLE decision cycle are part of the gap, hence the -2.
      IFG: begin
        if (ifg_cnt == IFG_W'(IFG_CLKS - 2)) state_d = IDLE;
        else ifg_d = ifg_cnt + IFG_W'(1);
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      rr_ptr     <= PAGE_W'(NUM_REQ - 1);
      ifg_cnt    <= '0;
      seen_ready <= 1'b0;
      ready_q    <= 1'b0;
      o_grant    <= '0;
      o_done     <= '0;
      o_err      <= '0;
      o_tx_en    <= 1'b0;
      o_tx_size  <= '0;
      o_ram_page <= '0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_d;
      ifg_cnt    <= ifg_d;
      seen_ready <= seen_d;
      ready_q    <= i_tx_ready;
      o_grant    <= grant_d;
      o_done     <= done_d;
      o_err      <= err_d;
      o_tx_en    <= tx_en_d;
      o_tx_size  <= size_d;
      o_ram_page <= page_d;
    end
  end

`ifdef ETH_TX_ARB_STATS_EN
  // Counters advance on the same edge as the pulse they count and wrap naturally.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_frm_cnt <= '0;
      o_rej_cnt <= '0;
    end else begin
      if (|done_d) o_frm_cnt <= o_frm_cnt + 16'd1;
      if (|err_d)  o_rej_cnt <= o_rej_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed self-checking bench for eth_tx_arb with a small eth_tx engine model.
module tb_eth_tx_arb;

  localparam int FRAME_CLKS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [43:0] size;
  logic [3:0]  grant, done, err;
  logic        tx_en;
  logic        tx_ready = 1'b1;
  logic [10:0] tx_size;
  logic [1:0]  ram_page;
`ifdef ETH_TX_ARB_STATS_EN
  logic [15:0] frm_cnt, rej_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eth_tx_arb dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_req      (req),
    .i_size     (size),
    .o_grant    (grant),
    .o_done     (done),
    .o_err      (err),
    .o_tx_en    (tx_en),
    .i_tx_ready (tx_ready),
    .o_tx_size  (tx_size),
    .o_ram_page (ram_page)
`ifdef ETH_TX_ARB_STATS_EN
    ,
    .o_frm_cnt  (frm_cnt),
    .o_rej_cnt  (rej_cnt)
`endif
  );

  // eth_tx model: takes a start when ready, stays busy FRAME_CLKS clocks.
  int busy = 0;
  always @(posedge clk) begin
    if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1) tx_ready <= 1'b1;
    end else if (tx_en && tx_ready) begin
      tx_ready <= 1'b0;
      busy     <= FRAME_CLKS;
    end
  end

  // Event monitor: samples the cycle that just ended.
  int cyc = 0, run = 0, last_run = 0, done_total = 0, err_total = 0, overlap = 0;
  int last_grant_cyc = 0, last_done_cyc = 0;
  logic [3:0] gprev = '0;
  logic [3:0] grant_log[$];
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (tx_en) run = run + 1;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (grant != 0 && gprev == 0) begin
      grant_log.push_back(grant);
      last_grant_cyc = cyc;
    end
    gprev = grant;
    if (done != 0) begin
      done_total = done_total + 1;
      last_done_cyc = cyc;
    end
    if (err != 0) err_total = err_total + 1;
    if (done != 0 && grant != 0) overlap = overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_size(input int idx, input int val);
    size[idx*11 +: 11] = 11'(val);
  endtask

  task automatic wait_grant(input string tag, input int idx, input int sz);
    bit hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (grant != 0) begin
        hit = 1;
        break;
      end
    end
    chk({tag, "_grant"}, 32'(grant), 32'(1) << idx);
    if (hit) begin
      chk({tag, "_page"}, 32'(ram_page), 32'(idx));
      chk({tag, "_size"}, 32'(tx_size), 32'(sz));
    end
  endtask

  task automatic wait_done(input string tag, input int idx);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done != 0) break;
    end
    chk({tag, "_done"}, 32'(done), 32'(1) << idx);
  endtask

  task automatic wait_err(input string tag, input int idx);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (err != 0) break;
    end
    chk({tag, "_err"}, 32'(err), 32'(1) << idx);
    chk({tag, "_err_nogrant"}, 32'(grant), 32'd0);
    chk({tag, "_err_notxen"}, 32'(tx_en), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, dbefore;
    bit seen;
    rst_n = 1'b0;
    req   = '0;
    size  = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_txen", 32'(tx_en), 0);
    chk("rst_size", 32'(tx_size), 0);
    chk("rst_page", 32'(ram_page), 0);
    rst_n = 1'b1;

    // Single request, size change after grant ignored, two-clock start strobe.
    set_size(0, 64);
    req = 4'b0001;
    wait_grant("t1", 0, 64);
    set_size(0, 999);
    wait_done("t1", 0);
    chk("t1_txen_len", 32'(last_run), 2);
    chk("t1_size_hold", 32'(tx_size), 64);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 0);

    // Inter-frame gap with req0 still held.
    set_size(0, 64);
    wait_grant("t2", 0, 64);
    @(posedge clk); #1;
    chk("t2_ifg", 32'(last_grant_cyc - last_done_cyc), 48);
    wait_done("t2", 0);
    req = '0;

    // Round-robin from reset with all requesters held.
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_size(0, 64);
    set_size(1, 100);
    set_size(2, 1500);
    set_size(3, 1);
    base = grant_log.size();
    req = 4'b1111;
    wait_grant("t3a", 0, 64);
    wait_done("t3a", 0);
    wait_grant("t3b", 1, 100);
    wait_done("t3b", 1);
    wait_grant("t3c", 2, 1500);
    wait_done("t3c", 2);
    wait_grant("t3d", 3, 1);
    wait_done("t3d", 3);
    wait_grant("t3e", 0, 64);
    wait_done("t3e", 0);
    req = '0;
    @(posedge clk); #1;
    chk("t3_log_len", 32'(grant_log.size() - base), 5);

    // Illegal sizes: rejected, then the pending req2 is granted next cycle.
    set_size(1, 1501);
    set_size(2, 200);
    req = 4'b0110;
    wait_err("t4a", 1);
    req = 4'b0100;
    @(negedge clk);
    chk("t4a_next_grant", 32'(grant), 32'b0100);
    chk("t4a_err_clear", 32'(err), 0);
    chk("t4a_size", 32'(tx_size), 200);
    wait_done("t4a", 2);
    set_size(1, 0);
    req = 4'b0110;
    wait_err("t4b", 1);
    req = 4'b0100;
    @(negedge clk);
    chk("t4b_next_grant", 32'(grant), 32'b0100);
    wait_done("t4b", 2);
    req = '0;

    // Reset during WAIT_DONE abandons the frame.
    set_size(3, 300);
    req = 4'b1000;
    wait_grant("t5", 3, 300);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_en) seen = 1;
      else if (seen) break;
    end
    chk("t5_in_wait", 32'(seen && !tx_en), 1);
    dbefore = done_total;
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    chk("t5_rst_grant", 32'(grant), 0);
    chk("t5_rst_txen", 32'(tx_en), 0);
    chk("t5_rst_size", 32'(tx_size), 0);
    chk("t5_rst_page", 32'(ram_page), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_no_done", 32'(done_total - dbefore), 0);
    req = 4'b1001;
    wait_grant("t5_after", 0, 64);
    req = 4'b1000;
    wait_done("t5_after", 0);
    wait_grant("t5_drop", 3, 300);
    req = '0;
    wait_done("t5_drop", 3);

`ifdef ETH_TX_ARB_STATS_EN
    set_size(1, 0);
    req = 4'b0010;
    wait_err("t6", 1);
    req = 4'b0100;
    wait_grant("t6", 2, 200);
    req = '0;
    wait_done("t6", 2);
    @(negedge clk);
    chk("t6_frm_cnt", 32'(frm_cnt), 3);
    chk("t6_rej_cnt", 32'(rej_cnt), 1);
`endif

    repeat (3) @(negedge clk);
    chk("overlap", 32'(overlap), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
